// File: rtl/tl_uh_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tl_uh_pkg
// Description : Shared TL-UH opcode constants, machine-timer register map
//               and byte-mask helper.
// Revision    : 1.0 - initial release
// ============================================================================
package tl_uh_pkg;

   // A-channel request opcodes
   localparam logic [2:0] TL_PUTFULL    = 3'd0;
   localparam logic [2:0] TL_PUTPARTIAL = 3'd1;
   localparam logic [2:0] TL_ARITH      = 3'd2;
   localparam logic [2:0] TL_LOGICAL    = 3'd3;
   localparam logic [2:0] TL_GET        = 3'd4;
   localparam logic [2:0] TL_INTENT     = 3'd5;

   // D-channel response opcodes
   localparam logic [2:0] TL_ACK        = 3'd0;
   localparam logic [2:0] TL_ACKDATA    = 3'd1;

   // Word index (address[4:2]) of each machine-timer register
   typedef enum logic [2:0] {
      REG_MTIME_LO    = 3'd0,
      REG_MTIME_HI    = 3'd1,
      REG_MTIMECMP_LO = 3'd2,
      REG_MTIMECMP_HI = 3'd3,
      REG_CTRL        = 3'd4,
      REG_RSVD_5      = 3'd5,
      REG_RSVD_6      = 3'd6,
      REG_RSVD_7      = 3'd7
   } mtimer_reg_e;

   // Expand a 4-bit byte-lane mask into a 32-bit bit mask
   function automatic logic [31:0] expand_mask(input logic [3:0] m);
      return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
   endfunction

endpackage
`default_nettype wire

// File: rtl/tl_uh_resp_slot.sv
`default_nettype none
// ============================================================================
// Module      : tl_uh_resp_slot
// Description : Single-entry TL-UH D-channel holding register. Accepts a new
//               request whenever the slot is empty or being drained, so a
//               ready sink sees one response per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tl_uh_resp_slot #(
   parameter int SOURCE_W = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                a_valid,
   output logic                a_ready,
   output logic                accept,
   input  logic [2:0]          load_opcode,
   input  logic [3:0]          load_size,
   input  logic [SOURCE_W-1:0] load_source,
   input  logic                load_denied,
   input  logic [31:0]         load_data,
   output logic [2:0]          d_opcode,
   output logic [1:0]          d_param,
   output logic [3:0]          d_size,
   output logic [SOURCE_W-1:0] d_source,
   output logic                d_denied,
   output logic [31:0]         d_data,
   output logic                d_corrupt,
   output logic                d_valid,
   input  logic                d_ready
);

   assign a_ready   = !d_valid || d_ready;
   assign accept    = a_valid && a_ready;
   assign d_param   = 2'b00;
   assign d_corrupt = 1'b0;

   // Capture the response on accept; drop it once the sink takes it
   always_ff @(posedge clk) begin
      if (rst) begin
         d_valid  <= 1'b0;
         d_opcode <= 3'd0;
         d_size   <= 4'd0;
         d_source <= '0;
         d_denied <= 1'b0;
         d_data   <= 32'd0;
      end else if (accept) begin
         d_valid  <= 1'b1;
         d_opcode <= load_opcode;
         d_size   <= load_size;
         d_source <= load_source;
         d_denied <= load_denied;
         d_data   <= load_data;
      end else if (d_ready) begin
         d_valid  <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: rtl/tilelink_machine_timer.sv
`default_nettype none
// ============================================================================
// Module      : tilelink_machine_timer
// Description : TL-UH slave holding the RISC-V mtime / mtimecmp pair and a
//               control word; drives the level machine timer interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module tilelink_machine_timer
   import tl_uh_pkg::*;
#(
   parameter int TL_SOURCE_W = 1,
   parameter int TL_ADDR_W   = 5,
   parameter int PRESCALE    = 1
) (
   input  logic                   tilelink_clock_i,
   input  logic                   tilelink_reset_i,
   input  logic [2:0]             a_opcode,
   input  logic [2:0]             a_param,
   input  logic [3:0]             a_size,
   input  logic [TL_SOURCE_W-1:0] a_source,
   input  logic [TL_ADDR_W-1:0]   a_address,
   input  logic [3:0]             a_mask,
   input  logic [31:0]            a_data,
   input  logic                   a_corrupt,
   input  logic                   a_valid,
   output logic                   a_ready,
   output logic [2:0]             d_opcode,
   output logic [1:0]             d_param,
   output logic [3:0]             d_size,
   output logic [TL_SOURCE_W-1:0] d_source,
   output logic                   d_denied,
   output logic [31:0]            d_data,
   output logic                   d_corrupt,
   output logic                   d_valid,
   input  logic                   d_ready,
   output logic                   timer_irq_o
);

   localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

   logic [63:0]     mtime, mtimecmp, mtime_next, mtimecmp_next, ticked;
   logic            count_en, irq_en, count_en_next, irq_en_next;
   logic [PS_W-1:0] prescaler;
   logic            tick, accept, is_put, denied, wr;
   logic [2:0]      resp_opcode;
   logic [31:0]     read_word, resp_data, wmask;
   mtimer_reg_e     reg_sel;
   logic            unused_bits;

   assign reg_sel     = mtimer_reg_e'(a_address[4:2]);
   assign wmask       = expand_mask(a_mask);
   assign unused_bits = ^{a_param, a_address};

   // Request decode: legality, ack opcode and read data at accept time
   always_comb begin
      is_put = (a_opcode == TL_PUTFULL) || (a_opcode == TL_PUTPARTIAL);
      denied = !(is_put || (a_opcode == TL_GET)) || (a_size > 4'd2) ||
               (is_put && a_corrupt);
      case (a_opcode)
         TL_GET, TL_ARITH, TL_LOGICAL: resp_opcode = TL_ACKDATA;
         default:                      resp_opcode = TL_ACK;
      endcase
      case (reg_sel)
         REG_MTIME_LO:    read_word = mtime[31:0];
         REG_MTIME_HI:    read_word = mtime[63:32];
         REG_MTIMECMP_LO: read_word = mtimecmp[31:0];
         REG_MTIMECMP_HI: read_word = mtimecmp[63:32];
         REG_CTRL:        read_word = {30'd0, irq_en, count_en};
         default:         read_word = 32'd0;
      endcase
      resp_data = ((a_opcode == TL_GET) && !denied) ? read_word : 32'd0;
      wr        = accept && is_put && !denied;
   end

   // Next-state of counter, compare and control; a write beats the tick
   // on the bytes it touches and suppresses carry into the other word
   always_comb begin
      tick          = count_en && (prescaler == PS_LAST);
      ticked        = tick ? (mtime + 64'd1) : mtime;
      mtime_next    = ticked;
      mtimecmp_next = mtimecmp;
      count_en_next = count_en;
      irq_en_next   = irq_en;
      if (wr) begin
         case (reg_sel)
            REG_MTIME_LO:
               mtime_next = {mtime[63:32], (ticked[31:0] & ~wmask) | (a_data & wmask)};
            REG_MTIME_HI:
               mtime_next = {(ticked[63:32] & ~wmask) | (a_data & wmask), mtime[31:0]};
            REG_MTIMECMP_LO:
               mtimecmp_next[31:0] = (mtimecmp[31:0] & ~wmask) | (a_data & wmask);
            REG_MTIMECMP_HI:
               mtimecmp_next[63:32] = (mtimecmp[63:32] & ~wmask) | (a_data & wmask);
            REG_CTRL:
               if (a_mask[0]) {irq_en_next, count_en_next} = a_data[1:0];
            default: ;
         endcase
      end
   end

   // Timer state, prescaler and registered interrupt
   always_ff @(posedge tilelink_clock_i) begin
      if (tilelink_reset_i) begin
         mtime       <= 64'd0;
         mtimecmp    <= 64'hFFFF_FFFF_FFFF_FFFF;
         count_en    <= 1'b1;
         irq_en      <= 1'b0;
         prescaler   <= '0;
         timer_irq_o <= 1'b0;
      end else begin
         mtime       <= mtime_next;
         mtimecmp    <= mtimecmp_next;
         count_en    <= count_en_next;
         irq_en      <= irq_en_next;
         if (count_en) prescaler <= (prescaler == PS_LAST) ? '0 : prescaler + PS_W'(1);
         timer_irq_o <= irq_en_next && (mtime_next >= mtimecmp_next);
      end
   end

   tl_uh_resp_slot #(
      .SOURCE_W (TL_SOURCE_W)
   ) u_resp_slot (
      .clk         (tilelink_clock_i),
      .rst         (tilelink_reset_i),
      .a_valid     (a_valid),
      .a_ready     (a_ready),
      .accept      (accept),
      .load_opcode (resp_opcode),
      .load_size   (a_size),
      .load_source (a_source),
      .load_denied (denied),
      .load_data   (resp_data),
      .d_opcode    (d_opcode),
      .d_param     (d_param),
      .d_size      (d_size),
      .d_source    (d_source),
      .d_denied    (d_denied),
      .d_data      (d_data),
      .d_corrupt   (d_corrupt),
      .d_valid     (d_valid),
      .d_ready     (d_ready)
   );

endmodule
`default_nettype wire

// File: tb/tb_tilelink_machine_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_tilelink_machine_timer
// Description : Scoreboard bench for tilelink_machine_timer (PRESCALE=1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tilelink_machine_timer;

   logic        clk, rst;
   logic [2:0]  a_opcode, a_param;
   logic [3:0]  a_size, a_mask;
   logic [0:0]  a_source;
   logic [4:0]  a_address;
   logic [31:0] a_data;
   logic        a_corrupt, a_valid, a_ready;
   logic [2:0]  d_opcode;
   logic [1:0]  d_param;
   logic [3:0]  d_size;
   logic [0:0]  d_source;
   logic        d_denied, d_corrupt, d_valid, d_ready;
   logic [31:0] d_data;
   logic        timer_irq_o;

   typedef struct packed {
      logic [2:0]  op;
      logic        den;
      logic [31:0] data;
      logic [3:0]  size;
      logic        src;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   logic src_tog = 1'b0;
   int   resp_n = 0;

   tilelink_machine_timer #(.TL_SOURCE_W(1), .TL_ADDR_W(5), .PRESCALE(1)) dut (
      .tilelink_clock_i (clk),
      .tilelink_reset_i (rst),
      .a_opcode  (a_opcode),  .a_param  (a_param),  .a_size (a_size),
      .a_source  (a_source),  .a_address(a_address), .a_mask (a_mask),
      .a_data    (a_data),    .a_corrupt(a_corrupt), .a_valid(a_valid),
      .a_ready   (a_ready),
      .d_opcode  (d_opcode),  .d_param  (d_param),  .d_size (d_size),
      .d_source  (d_source),  .d_denied (d_denied), .d_data (d_data),
      .d_corrupt (d_corrupt), .d_valid  (d_valid),  .d_ready(d_ready),
      .timer_irq_o (timer_irq_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s got %h want %h", name, act, req);
      end
   endtask

   // Drive request fields and push the expected response
   task automatic drive_req(input logic [2:0] op, input logic [4:0] addr, input logic [3:0] size,
                            input logic [3:0] mask, input logic [31:0] data, input logic corrupt,
                            input logic [2:0] eop, input logic eden, input logic [31:0] edata);
      exp_t e;
      a_opcode = op; a_param = 3'd0; a_size = size; a_address = addr;
      a_mask = mask; a_data = data; a_corrupt = corrupt; a_source = src_tog;
      a_valid = 1'b1;
      e.op = eop; e.den = eden; e.data = edata; e.size = size; e.src = src_tog;
      exp_q.push_back(e);
      src_tog = ~src_tog;
   endtask

   // Issue one request at a negedge; returns at the negedge after acceptance
   task automatic issue(input logic [2:0] op, input logic [4:0] addr, input logic [3:0] size,
                        input logic [3:0] mask, input logic [31:0] data, input logic corrupt,
                        input logic [2:0] eop, input logic eden, input logic [31:0] edata);
      bit got = 0;
      drive_req(op, addr, size, mask, data, corrupt, eop, eden, edata);
      for (int n = 0; n < 100 && !got; n++) begin
         #1 got = a_ready;
         @(posedge clk);
         @(negedge clk);
      end
      a_valid = 1'b0;
      if (!got) begin
         checks++; errors++;
         $display("FAIL accept_timeout addr %h got no a_ready want a_ready", addr);
      end
   endtask

   // Monitor: compare every delivered response against the scoreboard
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #1;
         if (d_valid && d_ready && !rst) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_resp got op=%0d data=%h want none", d_opcode, d_data);
            end else begin
               e = exp_q.pop_front();
               if (d_opcode !== e.op || d_denied !== e.den || d_data !== e.data ||
                   d_size !== e.size || d_source !== e.src || d_param !== 2'd0 || d_corrupt !== 1'b0) begin
                  errors++;
                  $display("FAIL resp%0d got op=%0d den=%0b data=%h size=%0d src=%0b want op=%0d den=%0b data=%h size=%0d src=%0b",
                           resp_n, d_opcode, d_denied, d_data, d_size, d_source,
                           e.op, e.den, e.data, e.size, e.src);
               end
            end
            resp_n++;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog got timeout want finish");
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; d_ready = 1'b1; a_valid = 1'b0;
      a_opcode = 3'd0; a_param = 3'd0; a_size = 4'd2; a_source = 1'b0;
      a_address = 5'd0; a_mask = 4'hF; a_data = 32'd0; a_corrupt = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("reset_d_valid", d_valid, 0);
      chk("reset_irq", timer_irq_o, 0);
      chk("reset_a_ready", a_ready, 1);
      rst = 1'b0;

      // 1: free-running count from reset
      repeat (10) @(posedge clk);
      @(negedge clk);
      issue(3'd4, 5'h00, 4'd2, 4'hF, 32'd0, 1'b0, 3'd1, 1'b0, 32'd10);

      // 2: carry from lo into hi with the counter gated
      issue(3'd0, 5'h10, 4'd2, 4'hF, 32'd0,          1'b0, 3'd0, 1'b0, 32'd0);
      issue(3'd0, 5'h00, 4'd2, 4'hF, 32'hFFFF_FFFF,  1'b0, 3'd0, 1'b0, 32'd0);
      issue(3'd0, 5'h04, 4'd2, 4'hF, 32'd0,          1'b0, 3'd0, 1'b0, 32'd0);
      issue(3'd0, 5'h10, 4'd2, 4'hF, 32'd1,          1'b0, 3'd0, 1'b0, 32'd0);
      issue(3'd0, 5'h10, 4'd2, 4'hF, 32'd0,          1'b0, 3'd0, 1'b0, 32'd0);
      issue(3'd4, 5'h04, 4'd2, 4'hF, 32'd0,          1'b0, 3'd1, 1'b0, 32'd1);
      issue(3'd4, 5'h00, 4'd2, 4'hF, 32'd0,          1'b0, 3'd1, 1'b0, 32'd0);
      issue(3'd4, 5'h10, 4'd2, 4'hF, 32'd0,          1'b0, 3'd1, 1'b0, 32'd0);

      // 3: interrupt rises at mtime==mtimecmp, falls when compare is raised
      issue(3'd0, 5'h04, 4'd2, 4'hF, 32'd0,  1'b0, 3'd0, 1'b0, 32'd0);
      issue(3'd0, 5'h00, 4'd2, 4'hF, 32'd10, 1'b0, 3'd0, 1'b0, 32'd0);
      issue(3'd0, 5'h0C, 4'd2, 4'hF, 32'd0,  1'b0, 3'd0, 1'b0, 32'd0);
      issue(3'd0, 5'h08, 4'd2, 4'hF, 32'd20, 1'b0, 3'd0, 1'b0, 32'd0);
      issue(3'd0, 5'h10, 4'd2, 4'hF, 32'd3,  1'b0, 3'd0, 1'b0, 32'd0);
      #1 chk("irq_after_enable", timer_irq_o, 0);
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         #1 chk($sformatf("irq_tick%0d", i), timer_irq_o, (i >= 10) ? 1 : 0);
      end
      issue(3'd0, 5'h0C, 4'd2, 4'hF, 32'd1, 1'b0, 3'd0, 1'b0, 32'd0);
      #1 chk("irq_fall", timer_irq_o, 0);
      issue(3'd0, 5'h10, 4'd2, 4'hF, 32'd0, 1'b0, 3'd0, 1'b0, 32'd0);

      // 4: partial write of a single byte lane
      issue(3'd0, 5'h08, 4'd2, 4'hF,    32'hFFFF_FFFF, 1'b0, 3'd0, 1'b0, 32'd0);
      issue(3'd1, 5'h08, 4'd2, 4'b0010, 32'h0000_AB00, 1'b0, 3'd0, 1'b0, 32'd0);
      issue(3'd4, 5'h08, 4'd2, 4'hF,    32'd0,         1'b0, 3'd1, 1'b0, 32'hFFFF_ABFF);

      // 5: back-pressure on D holds the response and blocks A
      @(negedge clk);
      d_ready = 1'b0;
      issue(3'd4, 5'h08, 4'd2, 4'hF, 32'd0, 1'b0, 3'd1, 1'b0, 32'hFFFF_ABFF);
      drive_req(3'd4, 5'h0C, 4'd2, 4'h0, 32'd0, 1'b0, 3'd1, 1'b0, 32'd1);
      for (int k = 0; k < 5; k++) begin
         #1;
         chk($sformatf("stall%0d_a_ready", k), a_ready, 0);
         chk($sformatf("stall%0d_d_valid", k), d_valid, 1);
         chk($sformatf("stall%0d_d_data", k), d_data, 32'hFFFF_ABFF);
         chk($sformatf("stall%0d_d_opcode", k), d_opcode, 3'd1);
         @(negedge clk);
      end
      d_ready = 1'b1;
      #1 chk("release_a_ready", a_ready, 1);
      @(posedge clk);
      @(negedge clk);
      a_valid = 1'b0;

      // 6: denied requests leave state untouched
      issue(3'd3, 5'h08, 4'd2, 4'hF, 32'd0,   1'b0, 3'd1, 1'b1, 32'd0);
      issue(3'd2, 5'h08, 4'd2, 4'hF, 32'd0,   1'b0, 3'd1, 1'b1, 32'd0);
      issue(3'd5, 5'h08, 4'd2, 4'hF, 32'd0,   1'b0, 3'd0, 1'b1, 32'd0);
      issue(3'd4, 5'h08, 4'd3, 4'hF, 32'd0,   1'b0, 3'd1, 1'b1, 32'd0);
      issue(3'd0, 5'h08, 4'd3, 4'hF, 32'd0,   1'b0, 3'd0, 1'b1, 32'd0);
      issue(3'd0, 5'h08, 4'd2, 4'hF, 32'd0,   1'b1, 3'd0, 1'b1, 32'd0);
      issue(3'd4, 5'h08, 4'd2, 4'h0, 32'd0,   1'b0, 3'd1, 1'b0, 32'hFFFF_ABFF);
      issue(3'd0, 5'h14, 4'd2, 4'hF, 32'd123, 1'b0, 3'd0, 1'b0, 32'd0);
      issue(3'd4, 5'h14, 4'd2, 4'hF, 32'd0,   1'b0, 3'd1, 1'b0, 32'd0);
      issue(3'd4, 5'h1C, 4'd2, 4'hF, 32'd0,   1'b0, 3'd1, 1'b0, 32'd0);
      issue(3'd0, 5'h10, 4'd1, 4'hF, 32'd2,   1'b0, 3'd0, 1'b0, 32'd0);
      issue(3'd4, 5'h10, 4'd0, 4'hF, 32'd0,   1'b0, 3'd1, 1'b0, 32'd2);

      // Reset while a response is stalled drops it
      @(negedge clk);
      d_ready = 1'b0;
      issue(3'd4, 5'h00, 4'd2, 4'hF, 32'd0, 1'b0, 3'd1, 1'b0, 32'd0);
      #1 chk("pre_reset_d_valid", d_valid, 1);
      rst = 1'b1;
      @(negedge clk);
      #1 chk("mid_reset_d_valid", d_valid, 0);
      void'(exp_q.pop_back());
      rst = 1'b0;
      d_ready = 1'b1;

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
